// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch bus: variable-latency req/ack with address and read data.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: fetches at pc over a req/ack bus, presents the instruction
// for one execute cycle, then advances pc by npc_op. Misalignment or ack timeout is sticky.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic                commit,
  input  logic [1:0]          npc_op,
  input  logic [31:0]         imm,
  input  logic [31:0]         rd1,
  output logic [31:0]         pc,
  output logic [31:0]         pc4,
  output logic                fault
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [1:0]  OP_PC_IMM  = 2'b01;
  localparam logic [1:0]  OP_RD1_IMM = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FLT   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      pc_nx, inst_nx, npc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             req_q;

  // Next-pc selection; only consumed in EXEC.
  always_comb begin
    npc = pc + 32'd4;
    case (npc_op)
      OP_PC_IMM:  npc = pc + imm;
      OP_RD1_IMM: npc = (rd1 + imm) & ~32'h1;
      default:    npc = pc + 32'd4;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    inst_nx  = inst;
    cnt_nx   = cnt;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          inst_nx  = imem.imem_rdata;
          cnt_nx   = '0;
          state_nx = EXEC;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_nx = FLT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      EXEC: begin
        if (npc[1:0] != 2'b00) begin
          state_nx = FLT;
        end else begin
          pc_nx    = npc;
          state_nx = FETCH;
        end
      end
      FLT:     state_nx = FLT;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pc4        <= RESET_PC + 32'd4;
      inst       <= NOP_INST;
      cnt        <= '0;
      req_q      <= 1'b0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      pc4        <= pc_nx + 32'd4;
      inst       <= inst_nx;
      cnt        <= cnt_nx;
      req_q      <= (state_nx == FETCH);
      inst_valid <= (state_nx == EXEC);
      fault      <= (state_nx == FLT);
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;
  assign commit         = inst_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table for the fetch/execute flow plus
// hand sequences for ack timeout and asynchronous reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, pc, pc4, imm, rd1;
  logic        inst_valid, commit, fault;
  logic [1:0]  npc_op;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(32'h0), .ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .inst(inst), .inst_valid(inst_valid), .commit(commit),
    .npc_op(npc_op), .imm(imm), .rd1(rd1),
    .pc(pc), .pc4(pc4), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic [1:0]  op;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic        req;
    logic        valid;
    logic        flt;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic valid, input logic flt,
                         input logic [31:0] epc, input logic [31:0] einst);
    chk({tag, ".req"},    32'(bus.imem_req), 32'(req));
    chk({tag, ".valid"},  32'(inst_valid), 32'(valid));
    chk({tag, ".commit"}, 32'(commit), 32'(valid));
    chk({tag, ".fault"},  32'(fault), 32'(flt));
    chk({tag, ".pc"},     pc, epc);
    chk({tag, ".pc4"},    pc4, epc + 32'd4);
    chk({tag, ".addr"},   bus.imem_addr, epc);
    chk({tag, ".inst"},   inst, einst);
  endtask

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic [1:0] op,
                              input logic [31:0] im, input logic [31:0] r1, input logic req,
                              input logic valid, input logic flt, input logic [31:0] epc,
                              input logic [31:0] einst);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.op = op; v.imm = im; v.rd1 = r1;
    v.req = req; v.valid = valid; v.flt = flt; v.pc = epc; v.inst = einst;
    return v;
  endfunction

  task automatic drive(input logic ack, input logic [31:0] rdata);
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
  endtask

  initial begin
    // Each row: inputs held for one cycle, then outputs expected after the next edge.
    vt[0]  = mk(1, 32'h0000_0BAD, 2'b00, 32'h0,         32'h0,         1, 0, 0, 32'h0,         32'h0000_0013);
    vt[1]  = mk(1, 32'h0050_0093, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h0050_0093);
    vt[2]  = mk(0, 32'h0,         2'b00, 32'h0,         32'h0,         1, 0, 0, 32'h4,         32'h0050_0093);
    vt[3]  = mk(0, 32'h0,         2'b00, 32'h0,         32'h0,         1, 0, 0, 32'h4,         32'h0050_0093);
    vt[4]  = mk(0, 32'h0,         2'b00, 32'h0,         32'h0,         1, 0, 0, 32'h4,         32'h0050_0093);
    vt[5]  = mk(1, 32'h00A0_0113, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h4,         32'h00A0_0113);
    vt[6]  = mk(1, 32'hDEAD_BEEF, 2'b01, 32'h0000_00FC, 32'h0,         1, 0, 0, 32'h100,       32'h00A0_0113);
    vt[7]  = mk(1, 32'h1111_1111, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h100,       32'h1111_1111);
    vt[8]  = mk(0, 32'h0,         2'b01, 32'hFFFF_FFF8, 32'h0,         1, 0, 0, 32'hF8,        32'h1111_1111);
    vt[9]  = mk(1, 32'h2222_2222, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'hF8,        32'h2222_2222);
    vt[10] = mk(0, 32'h0,         2'b10, 32'h0,         32'hFFFF_FFFC, 1, 0, 0, 32'hFFFF_FFFC, 32'h2222_2222);
    vt[11] = mk(1, 32'h3333_3333, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'hFFFF_FFFC, 32'h3333_3333);
    vt[12] = mk(0, 32'h0,         2'b00, 32'h0,         32'h0,         1, 0, 0, 32'h0,         32'h3333_3333);
    vt[13] = mk(1, 32'h4444_4444, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h0,         32'h4444_4444);
    vt[14] = mk(0, 32'h0,         2'b11, 32'h1234_0000, 32'h0,         1, 0, 0, 32'h4,         32'h4444_4444);
    vt[15] = mk(1, 32'h5555_5555, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h4,         32'h5555_5555);
    vt[16] = mk(0, 32'h0,         2'b10, 32'h0,         32'h201,       1, 0, 0, 32'h200,       32'h5555_5555);
    vt[17] = mk(1, 32'h6666_6666, 2'b00, 32'h0,         32'h0,         0, 1, 0, 32'h200,       32'h6666_6666);
    vt[18] = mk(0, 32'h0,         2'b10, 32'h0,         32'h203,       0, 0, 1, 32'h200,       32'h6666_6666);
    vt[19] = mk(1, 32'h7777_7777, 2'b00, 32'h0,         32'h0,         0, 0, 1, 32'h200,       32'h6666_6666);

    rst_n = 1'b0;
    drive(0, 32'h0);
    npc_op = 2'b00; imm = 32'h0; rd1 = 32'h0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 32'h0, 32'h0000_0013);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].ack, vt[i].rdata);
      npc_op = vt[i].op; imm = vt[i].imm; rd1 = vt[i].rd1;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].req, vt[i].valid, vt[i].flt, vt[i].pc, vt[i].inst);
    end

    // Async reset out of FAULT clears fault without a clock edge.
    #2 rst_n = 1'b0;
    #1 chk_all("flt_rst", 0, 0, 0, 32'h0, 32'h0000_0013);
    tick();
    rst_n = 1'b1;
    drive(0, 32'h0); npc_op = 2'b00; imm = 32'h0; rd1 = 32'h0;

    // Ack timeout: FETCH holds for 15 edges, FAULT on the 16th.
    tick();
    chk_all("to_first", 1, 0, 0, 32'h0, 32'h0000_0013);
    for (int c = 1; c < 16; c++) begin
      tick();
      if (c < 15) begin
        chk($sformatf("to_req%0d", c), 32'(bus.imem_req), 32'd1);
      end else begin
        chk_all("to_last_fetch", 1, 0, 0, 32'h0, 32'h0000_0013);
      end
    end
    tick();
    chk_all("to_fault", 0, 0, 1, 32'h0, 32'h0000_0013);
    drive(1, 32'hCAFE_F00D);
    tick();
    chk_all("to_late_ack", 0, 0, 1, 32'h0, 32'h0000_0013);

    // Mid-FETCH reset with ack pending abandons the request at once.
    #2 rst_n = 1'b0;
    #1 chk($sformatf("to_rst_fault"), 32'(fault), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 32'h0);
    tick();
    drive(1, 32'h0010_0093);
    tick();
    chk_all("mr_exec", 0, 1, 0, 32'h0, 32'h0010_0093);
    drive(0, 32'h0);
    tick();
    chk_all("mr_fetch4", 1, 0, 0, 32'h4, 32'h0010_0093);
    drive(1, 32'h0BAD_0BAD);
    #2 rst_n = 1'b0;
    #1 chk_all("mr_async", 0, 0, 0, 32'h0, 32'h0000_0013);
    tick();
    rst_n = 1'b1;
    drive(0, 32'h0);
    tick();
    chk_all("mr_refetch", 1, 0, 0, 32'h0, 32'h0000_0013);
    drive(1, 32'h0020_0093);
    tick();
    chk_all("mr_exec2", 0, 1, 0, 32'h0, 32'h0020_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
